// File: rtl/serial_add_tree.sv
// Bit-serial adder tree: NOPS operands serialized LSB first through a tree of full adders.
// Optional saturation of the result is enabled by defining SERIAL_SAT_EN.
module serial_add_tree #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NOPS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NOPS*WIDTH-1:0] ops,
    input  logic                  sgn,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      sum,
    output logic                  ovf
);

    localparam int unsigned LEVELS = $clog2(NOPS);
    localparam int unsigned SW     = WIDTH + LEVELS;
    localparam int unsigned LAST   = WIDTH + 2 * LEVELS;
    localparam int unsigned CW     = $clog2(LAST + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   ser [NOPS];
    logic [NOPS-1:1] sbit;
    logic [NOPS-1:1] carry;
    logic [SW-1:0]   acc;
    logic            sgn_q;

    // Heap-ordered tree nodes: 1 is the root, NOPS..2*NOPS-1 are the serializer outputs.
    logic [2*NOPS-1:1] node;
    always_comb begin
        node = '0;
        for (int unsigned i = 1; i < NOPS; i++) node[i] = sbit[i];
        for (int unsigned i = 0; i < NOPS; i++) node[NOPS+i] = ser[i][0];
    end

    // Range check and wrap/saturate of the exact sum collected from the root.
    logic [WIDTH-1:0] sum_c;
    logic             ovf_c;
    always_comb begin
        logic [LEVELS:0] hi;
        hi = acc[SW-1:WIDTH-1];
        if (sgn_q) ovf_c = !((&hi) || !(|hi));
        else       ovf_c = |acc[SW-1:WIDTH];
        sum_c = acc[WIDTH-1:0];
`ifdef SERIAL_SAT_EN
        if (ovf_c) begin
            if (!sgn_q)          sum_c = '1;
            else if (acc[SW-1])  sum_c = {1'b1, {(WIDTH-1){1'b0}}};
            else                 sum_c = {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            sgn_q     <= 1'b0;
            sbit      <= '0;
            carry     <= '0;
            acc       <= '0;
            for (int unsigned i = 0; i < NOPS; i++) ser[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < NOPS; i++)
                            ser[i] <= {{LEVELS{sgn & ops[i*WIDTH+WIDTH-1]}}, ops[i*WIDTH +: WIDTH]};
                        sgn_q    <= sgn;
                        sbit     <= '0;
                        carry    <= '0;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Arithmetic shift keeps emitting the extension bit once the operand is exhausted.
                    for (int unsigned i = 0; i < NOPS; i++)
                        ser[i] <= {ser[i][SW-1], ser[i][SW-1:1]};
                    for (int unsigned i = 1; i < NOPS; i++) begin
                        sbit[i]  <= node[2*i] ^ node[2*i+1] ^ carry[i];
                        carry[i] <= (node[2*i] & node[2*i+1]) | (node[2*i] & carry[i]) |
                                    (node[2*i+1] & carry[i]);
                    end
                    acc <= {node[1], acc[SW-1:1]};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(LAST)) begin
                        sum       <= sum_c;
                        ovf       <= ovf_c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_tree.sv
// Scoreboard bench for serial_add_tree (WIDTH=8, NOPS=4); honours SERIAL_SAT_EN.
module tb_serial_add_tree;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NOPS  = 4;
    localparam int          LAT   = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      ops;
    logic             sgn;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             ovf;

    typedef struct packed {
        logic [7:0] sum;
        logic       ovf;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_add_tree #(.WIDTH(WIDTH), .NOPS(NOPS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ops(ops),
        .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact integer reference for the sum, range check and wrap/saturate.
    function automatic exp_t model(input logic [31:0] o, input logic s);
        int total = 0;
        logic signed [7:0] sv;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            sv = o[i*8 +: 8];
            total += s ? int'(sv) : int'(o[i*8 +: 8]);
        end
        e.ovf = s ? (total < -128 || total > 127) : (total > 255);
        e.sum = total[7:0];
`ifdef SERIAL_SAT_EN
        if (e.ovf) e.sum = s ? (total < 0 ? 8'h80 : 8'h7F) : 8'hFF;
`endif
        return e;
    endfunction

    task automatic send(input logic [31:0] o, input logic s);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'(1));
        ops = o; sgn = s; in_valid = 1'b1;
        sbq.push_back(model(o, s));
        @(posedge clk); #1;
        in_valid = 1'b0; ops = $urandom; sgn = 1'($urandom);
    endtask

    task automatic receive(input int hold);
        int   n = 0;
        exp_t e;
        logic [7:0] s0;
        logic o0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(LAT));
        if (!out_valid) return;
        e = sbq.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        s0 = e.sum; o0 = e.ovf;
        repeat (hold) begin
            in_valid = 1'($urandom); ops = $urandom; sgn = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_sum", 32'(sum), 32'(s0));
            chk("hold_ovf", 32'(ovf), 32'(o0));
            chk("hold_in_ready", 32'(in_ready), 32'(0));
            chk("hold_out_valid", 32'(out_valid), 32'(1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", 32'(in_ready), 32'(1));
        chk("release_out_valid", 32'(out_valid), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; ops = '0; sgn = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; out_ready = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));

        // out_ready outside DONE must not disturb anything
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_out_ready", 32'(out_valid), 32'(0));

        send({8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);  receive(0);
        send({8'd0, 8'd0, 8'd1, 8'd255}, 1'b0);    receive(0);
        send({8'h80, 8'h80, 8'h80, 8'h80}, 1'b1);  receive(0);
        send({8'h01, 8'h01, 8'hFF, 8'hFF}, 1'b1);  receive(0);
        send({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0);  receive(0);
        send({8'h7F, 8'h7F, 8'h7F, 8'h7F}, 1'b1);  receive(5);
        send({8'h7F, 8'h00, 8'h00, 8'h00}, 1'b1);  receive(0);
        send({8'h80, 8'h00, 8'h00, 8'h00}, 1'b1);  receive(0);

        // Abort mid-shift with reset at the fifth edge after accept
        ops = {8'd9, 8'd9, 8'd9, 8'd9}; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'(0));
        chk("abort_in_ready", 32'(in_ready), 32'(1));
        chk("abort_sum", 32'(sum), 32'(0));
        repeat (15) @(posedge clk);
        #1;
        chk("abort_no_result", 32'(out_valid), 32'(0));

        send({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);      receive(0);

        for (int k = 0; k < 20; k++) begin
            send($urandom, 1'($urandom));
            receive(int'($urandom_range(0, 3)));
        end

        chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_add_tree.md
SERIAL_ADD_TREE -- requirements
Module: serial_add_tree

Interface
REQ-001 Parameter WIDTH, 8, operand and result width in bits (SHALL be >= 2).
REQ-002 Parameter NOPS, 4, operand count (SHALL be a power of 2, >= 2); LEVELS = log2(NOPS).
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port in_valid  input  1  operand set valid.
REQ-006 Port in_ready  output  1  block can accept an operand set.
REQ-007 Port ops  input  NOPS*WIDTH  operands; operand i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with ops.
REQ-009 Port out_valid  output  1  result valid.
REQ-010 Port out_ready  input  1  consumer accepts result.
REQ-011 Port sum  output  WIDTH  result.
REQ-012 Port ovf  output  1  exact sum not representable in WIDTH bits under sgn.

Function
REQ-013 FSM SHALL have states IDLE, SHIFT and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-014 Accept: in_valid && in_ready at a rising edge SHALL capture ops and sgn into NOPS parallel-to-serial registers and move IDLE -> SHIFT.
REQ-015 Serializers SHALL emit WIDTH+LEVELS bits, LSB first; bits past WIDTH SHALL be sign extension when sgn=1 and zero when sgn=0.
REQ-016 LEVELS ranks of bit-serial full adders SHALL form a binary tree; each adder SHALL register its sum bit and carry; carries SHALL be cleared on accept.
REQ-017 A serial-to-parallel register SHALL collect the WIDTH+LEVELS-bit exact sum from the tree root.
REQ-018 SHIFT -> DONE SHALL occur so that out_valid first asserts on the (WIDTH+2*LEVELS+1)-th rising edge after the accept edge; defaults give 13.
REQ-019 sum SHALL equal the exact sum modulo 2^WIDTH unless saturation applies (REQ-026).
REQ-020 ovf SHALL be 1 when the exact sum is >= 2^WIDTH (sgn=0) or outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] (sgn=1).
REQ-021 In DONE, sum and ovf SHALL hold stable until out_valid && out_ready, then DONE -> IDLE; in_ready is high on the following cycle.
REQ-022 in_valid, ops and sgn SHALL be ignored outside IDLE; only one transaction is in flight at a time.
REQ-023 out_ready outside DONE SHALL have no effect.

Reset
REQ-024 rst at a rising edge SHALL force IDLE, clear all shift, carry and result registers, and drive sum=0, ovf=0, out_valid=0, in_ready=1 from the next cycle.
REQ-025 rst in SHIFT or DONE SHALL abort the transaction with no result delivered; rst has priority over any simultaneous handshake.

Configuration
REQ-026 Macro SERIAL_SAT_EN defined: when ovf=1, sum SHALL clamp to 2^WIDTH-1 (sgn=0), or to 2^(WIDTH-1)-1 / -2^(WIDTH-1) by sign of the exact sum (sgn=1).
REQ-027 Macro SERIAL_SAT_EN undefined: sum SHALL be the wrapped value; ovf SHALL be reported identically in both builds.

Verification (WIDTH=8, NOPS=4)
REQ-028 sgn=0, ops 10,20,30,40, accept at edge 0 -> out_valid at edge 13, sum=100, ovf=0.
REQ-029 sgn=0, ops 255,1,0,0 -> ovf=1; sum=0x00 without SERIAL_SAT_EN, 0xFF with it.
REQ-030 sgn=1, ops 0x80 x4 (exact -512) -> ovf=1; sum=0x00 wrapped, 0x80 saturated; sgn=1, ops 0xFF,0xFF,0x01,0x01 -> sum=0, ovf=0.
REQ-031 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and ops -> sum/ovf stable, in_ready=0, no new accept; release -> in_ready=1 next cycle.
REQ-032 Assert rst for 1 cycle at edge 5 of SHIFT -> out_valid=0, in_ready=1, sum=0 next cycle; a following 1,2,3,4 transaction -> sum=10.
